lisnoc_router_output_credit: RTL and testbench

LISNOC_ROUTER_OUTPUT_CREDIT -- requirements
Module: lisnoc_router_output_credit

---
 rtl/lisnoc_router_output_credit.sv | 187 ++++++++++++++++++
 tb/tb_lisnoc_router_output_credit.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lisnoc_router_output_credit.sv
// Router output port: per-VC switch arbitration with packet locking, per-VC FIFOs,
// and a credit-gated round-robin link arbiter driving a registered outgoing flit.
module lisnoc_router_output_credit #(
    parameter int unsigned flit_data_width = 32,
    parameter int unsigned flit_type_width = 2,
    parameter int unsigned vchannels       = 2,
    parameter int unsigned ports           = 5,
    parameter int unsigned fifo_length     = 4,
    parameter int unsigned credits         = 4
) (
    input  logic                                                         clk,
    input  logic                                                         rst,
    input  logic [ports*vchannels-1:0]                                   switch_request,
    input  logic [(flit_data_width+flit_type_width)*vchannels*ports-1:0] switch_flit,
    output logic [ports*vchannels-1:0]                                   switch_read,
    output logic [flit_data_width+flit_type_width-1:0]                   link_flit,
    output logic [vchannels-1:0]                                         link_valid,
    input  logic [vchannels-1:0]                                         link_credit
);

    localparam int unsigned flit_width = flit_data_width + flit_type_width;
    localparam int unsigned port_w     = $clog2(ports);
    localparam int unsigned vc_w       = (vchannels > 1) ? $clog2(vchannels) : 1;
    localparam int unsigned idx_w      = $clog2(fifo_length);
    localparam int unsigned occ_w      = $clog2(fifo_length + 1);
    localparam int unsigned cnt_w      = $clog2(credits + 1);

    localparam logic [flit_type_width-1:0] type_header = flit_type_width'(1);
    localparam logic [flit_type_width-1:0] type_last   = flit_type_width'(2);

    // Per-VC state
    logic [port_w-1:0]     in_ptr     [vchannels];
    logic [vchannels-1:0]  locked;
    logic [port_w-1:0]     lock_port  [vchannels];
    logic [flit_width-1:0] mem        [vchannels][fifo_length];
    logic [idx_w-1:0]      rd_idx     [vchannels];
    logic [idx_w-1:0]      wr_idx     [vchannels];
    logic [occ_w-1:0]      count      [vchannels];
    logic [cnt_w-1:0]      credit_cnt [vchannels];
    logic [vc_w-1:0]       out_ptr;

    // Switch-side grant results
    logic [vchannels-1:0]       rd_valid;
    logic [port_w-1:0]          rd_port [vchannels];
    logic [flit_width-1:0]      rd_flit [vchannels];
    logic [flit_type_width-1:0] rd_type [vchannels];

    // Link-side selection
    logic [vchannels-1:0]  eligible;
    logic [vchannels-1:0]  send;
    logic [vc_w-1:0]       send_vc;
    logic [flit_width-1:0] send_flit;

    function automatic logic [idx_w-1:0] idx_inc(input logic [idx_w-1:0] idx);
        return (idx == idx_w'(fifo_length - 1)) ? '0 : idx + idx_w'(1);
    endfunction

    // Switch arbitration: locked VCs only serve their owner, otherwise round-robin from in_ptr
    always_comb begin
        switch_read = '0;
        for (int v = 0; v < vchannels; v++) begin
            rd_valid[v] = 1'b0;
            rd_port[v]  = '0;
            rd_flit[v]  = '0;
            if (!rst && count[v] != occ_w'(fifo_length)) begin
                if (locked[v]) begin
                    for (int p = 0; p < ports; p++) begin
                        if (lock_port[v] == port_w'(p) && switch_request[v*ports+p]) begin
                            rd_valid[v] = 1'b1;
                            rd_port[v]  = port_w'(p);
                        end
                    end
                end else begin
                    for (int p = 0; p < ports; p++) begin
                        if (!rd_valid[v] && port_w'(p) >= in_ptr[v] && switch_request[v*ports+p]) begin
                            rd_valid[v] = 1'b1;
                            rd_port[v]  = port_w'(p);
                        end
                    end
                    for (int p = 0; p < ports; p++) begin
                        if (!rd_valid[v] && switch_request[v*ports+p]) begin
                            rd_valid[v] = 1'b1;
                            rd_port[v]  = port_w'(p);
                        end
                    end
                end
            end
            for (int p = 0; p < ports; p++) begin
                if (rd_valid[v] && rd_port[v] == port_w'(p)) begin
                    switch_read[v*ports+p] = 1'b1;
                    rd_flit[v] = switch_flit[(p*vchannels+v)*flit_width +: flit_width];
                end
            end
            rd_type[v] = rd_flit[v][flit_width-1 -: flit_type_width];
        end
    end

    // Link arbitration: round-robin over VCs holding a flit and at least one credit
    always_comb begin
        send      = '0;
        send_vc   = '0;
        send_flit = '0;
        for (int v = 0; v < vchannels; v++) begin
            eligible[v] = (count[v] != '0) && (credit_cnt[v] != '0);
        end
        for (int v = 0; v < vchannels; v++) begin
            if (send == '0 && vc_w'(v) >= out_ptr && eligible[v]) begin
                send[v] = 1'b1;
                send_vc = vc_w'(v);
            end
        end
        for (int v = 0; v < vchannels; v++) begin
            if (send == '0 && eligible[v]) begin
                send[v] = 1'b1;
                send_vc = vc_w'(v);
            end
        end
        for (int v = 0; v < vchannels; v++) begin
            if (send[v]) begin
                send_flit = mem[v][rd_idx[v]];
            end
        end
    end

    // FIFO storage carries no reset; occupancy is tracked by count
    always_ff @(posedge clk) begin
        for (int v = 0; v < vchannels; v++) begin
            if (rd_valid[v]) begin
                mem[v][wr_idx[v]] <= rd_flit[v];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            link_valid <= '0;
            link_flit  <= '0;
            out_ptr    <= '0;
            locked     <= '0;
            for (int v = 0; v < vchannels; v++) begin
                in_ptr[v]     <= '0;
                lock_port[v]  <= '0;
                rd_idx[v]     <= '0;
                wr_idx[v]     <= '0;
                count[v]      <= '0;
                credit_cnt[v] <= cnt_w'(credits);
            end
        end else begin
            link_valid <= send;
            if (send != '0) begin
                link_flit <= send_flit;
                out_ptr   <= (send_vc == vc_w'(vchannels - 1)) ? '0 : send_vc + vc_w'(1);
            end
            for (int v = 0; v < vchannels; v++) begin
                if (rd_valid[v]) begin
                    wr_idx[v] <= idx_inc(wr_idx[v]);
                    in_ptr[v] <= (rd_port[v] == port_w'(ports - 1)) ? '0 : rd_port[v] + port_w'(1);
                    if (rd_type[v] == type_header) begin
                        locked[v]    <= 1'b1;
                        lock_port[v] <= rd_port[v];
                    end else if (rd_type[v] == type_last) begin
                        locked[v] <= 1'b0;
                    end
                end
                if (send[v]) begin
                    rd_idx[v] <= idx_inc(rd_idx[v]);
                end
                case ({rd_valid[v], send[v]})
                    2'b10:   count[v] <= count[v] + occ_w'(1);
                    2'b01:   count[v] <= count[v] - occ_w'(1);
                    default: count[v] <= count[v];
                endcase
                // Returned credits saturate at the downstream buffer size
                case ({send[v], link_credit[v]})
                    2'b10: credit_cnt[v] <= credit_cnt[v] - cnt_w'(1);
                    2'b01: begin
                        if (credit_cnt[v] != cnt_w'(credits)) begin
                            credit_cnt[v] <= credit_cnt[v] + cnt_w'(1);
                        end
                    end
                    default: credit_cnt[v] <= credit_cnt[v];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lisnoc_router_output_credit.sv
// Randomized and directed bench for lisnoc_router_output_credit; a queue-based reference
// model predicts grants and link traffic, and a negedge monitor scores the link.
module tb_lisnoc_router_output_credit;

    localparam int P  = 5;
    localparam int V  = 2;
    localparam int DW = 32;
    localparam int TW = 2;
    localparam int FW = DW + TW;
    localparam int FL = 4;
    localparam int CR = 4;

    localparam int T_PAY = 0;
    localparam int T_HDR = 1;
    localparam int T_LST = 2;
    localparam int T_SGL = 3;

    logic              clk;
    logic              rst;
    logic [P*V-1:0]    switch_request;
    logic [FW*V*P-1:0] switch_flit;
    logic [P*V-1:0]    switch_read;
    logic [FW-1:0]     link_flit;
    logic [V-1:0]      link_valid;
    logic [V-1:0]      link_credit;

    lisnoc_router_output_credit #(
        .flit_data_width(DW), .flit_type_width(TW), .vchannels(V),
        .ports(P), .fifo_length(FL), .credits(CR)
    ) dut (
        .clk(clk), .rst(rst),
        .switch_request(switch_request), .switch_flit(switch_flit),
        .switch_read(switch_read), .link_flit(link_flit),
        .link_valid(link_valid), .link_credit(link_credit)
    );

    typedef struct packed {
        int          cyc;
        logic [V-1:0] valid;
        logic [FW-1:0] flit;
    } exp_t;

    // Reference model: flit queues per VC, plain integer credits, ownership per VC
    logic [FW-1:0] mq   [V][$];
    logic [FW-1:0] pend [P*V][$];
    int            cred [V];
    bit            lk   [V];
    int            lkp  [V];
    int            iptr [V];
    int            optr;
    logic [FW-1:0] exp_hold;
    exp_t          sb[$];

    int            cyc;
    int            checks;
    int            errors;
    int            seq;
    logic [P*V-1:0] last_sr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(input int t, input int d);
        return {TW'(t), DW'(d)};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < V; v++) begin
            mq[v].delete();
            cred[v] = CR;
            lk[v]   = 1'b0;
            lkp[v]  = 0;
            iptr[v] = 0;
        end
        for (int i = 0; i < P*V; i++) pend[i].delete();
        optr     = 0;
        exp_hold = '0;
    endtask

    // One clock: drive pending flits, check predicted grants, advance the model at the edge
    task automatic step();
        logic [P*V-1:0] er;
        int             g  [V];
        logic [FW-1:0]  gf [V];
        int             sv;
        int             p;
        int             n;
        logic [FW-1:0]  f;
        exp_t           e;
        for (int pp = 0; pp < P; pp++) begin
            for (int v = 0; v < V; v++) begin
                switch_request[v*P+pp] = (pend[pp*V+v].size() != 0);
                switch_flit[(pp*V+v)*FW +: FW] = (pend[pp*V+v].size() != 0) ? pend[pp*V+v][0] : '0;
            end
        end
        #1;
        er = '0;
        for (int v = 0; v < V; v++) begin
            g[v]  = -1;
            gf[v] = '0;
            if (!rst && mq[v].size() < FL) begin
                if (lk[v]) begin
                    if (switch_request[v*P+lkp[v]]) g[v] = lkp[v];
                end else begin
                    for (int k = 0; k < P; k++) begin
                        p = (iptr[v] + k) % P;
                        if (g[v] < 0 && switch_request[v*P+p]) g[v] = p;
                    end
                end
            end
            if (g[v] >= 0) begin
                er[v*P+g[v]] = 1'b1;
                gf[v] = pend[g[v]*V+v][0];
            end
        end
        last_sr = switch_read;
        chk("switch_read", 64'(switch_read), 64'(er));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            sv = -1;
            for (int k = 0; k < V; k++) begin
                n = (optr + k) % V;
                if (sv < 0 && mq[n].size() > 0 && cred[n] > 0) sv = n;
            end
            if (sv >= 0) begin
                f       = mq[sv].pop_front();
                e.cyc   = cyc + 1;
                e.valid = V'(1) << sv;
                e.flit  = f;
                sb.push_back(e);
                exp_hold = f;
                optr     = (sv + 1) % V;
            end
            for (int v = 0; v < V; v++) begin
                n = cred[v] - ((sv == v) ? 1 : 0) + (link_credit[v] ? 1 : 0);
                cred[v] = (n > CR) ? CR : n;
                if (g[v] >= 0) begin
                    mq[v].push_back(gf[v]);
                    void'(pend[g[v]*V+v].pop_front());
                    iptr[v] = (g[v] + 1) % P;
                    if (int'(gf[v][FW-1 -: TW]) == T_HDR) begin
                        lk[v]  = 1'b1;
                        lkp[v] = g[v];
                    end else if (int'(gf[v][FW-1 -: TW]) == T_LST) begin
                        lk[v] = 1'b0;
                    end
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Link monitor: every valid beat must match the next scoreboard entry; idle beats hold the flit
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (link_valid != '0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL link_unexpected cycle=%0d got valid=%b flit=%h expected=no flit", cyc, link_valid, link_flit);
                end else begin
                    e = sb.pop_front();
                    chk("link_valid", 64'(link_valid), 64'(e.valid));
                    chk("link_flit", 64'(link_flit), 64'(e.flit));
                    chk("link_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                chk("link_hold", 64'(link_flit), 64'(exp_hold));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n0, first3, last0, bound;
        logic [V-1:0] prev;
        rst = 1'b1;
        link_credit = '0;
        switch_request = '0;
        switch_flit = '0;
        cyc = 0; checks = 0; errors = 0; seq = 0;
        model_reset();
        step(); step();
        rst = 1'b0;
        chk("reset_valid", 64'(link_valid), 64'(0));
        chk("reset_flit", 64'(link_flit), 64'(0));
        chk("reset_read", 64'(last_sr), 64'(0));

        // SINGLE on port 2, VC0: read now, on the link two cycles later
        pend[2*V+0].push_back(mk(T_SGL, 'hAA));
        step();
        chk("single_read", 64'(last_sr), 64'(1) << 2);
        step();
        chk("single_link_valid", 64'(link_valid), 64'(1));
        chk("single_link_flit", 64'(link_flit), 64'({2'b11, 32'h0000_00AA}));
        run(3);

        // Credit exhaustion then a single returned credit
        do_reset();
        for (int i = 0; i < 6; i++) pend[1*V+0].push_back(mk(T_SGL, 'h100 + i));
        n = 0;
        repeat (20) begin step(); if (link_valid[0]) n++; end
        chk("credit_limit", 64'(n), 64'(4));
        link_credit = 2'b01;
        n = 0;
        step(); if (link_valid[0]) n++;
        link_credit = 2'b00;
        repeat (10) begin step(); if (link_valid[0]) n++; end
        chk("credit_one_more", 64'(n), 64'(1));

        // Full FIFO with no credits blocks reads
        for (int i = 0; i < 6; i++) pend[1*V+0].push_back(mk(T_SGL, 'h110 + i));
        run(8);
        n = 0;
        repeat (5) begin step(); if (switch_read[0*P+1]) n++; end
        chk("full_blocks_read", 64'(n), 64'(0));

        // Drain with continuous credits, then saturation leaves exactly 4
        link_credit = 2'b11;
        run(30);
        link_credit = 2'b00;
        for (int i = 0; i < 6; i++) pend[1*V+0].push_back(mk(T_SGL, 'h120 + i));
        n = 0;
        repeat (20) begin step(); if (link_valid[0]) n++; end
        chk("credit_saturate", 64'(n), 64'(4));
        link_credit = 2'b11;
        run(15);

        // Both VCs busy with credits: link alternates VCs every cycle
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pend[0*V+0].push_back(mk(T_SGL, 'h400 + i));
            pend[4*V+1].push_back(mk(T_SGL, 'h500 + i));
        end
        run(3);
        prev = link_valid;
        chk("alt_start", 64'(prev != '0), 64'(1));
        for (int i = 0; i < 6; i++) begin
            step();
            prev = (prev == 2'b01) ? 2'b10 : 2'b01;
            chk("alternate", 64'(link_valid), 64'(prev));
        end
        run(20);

        // Packet lock: port 3 waits until port 0's LAST is read
        do_reset();
        for (int i = 0; i < 4; i++) pend[3*V+1].push_back(mk(T_SGL, 'h300 + i));
        pend[0*V+1].push_back(mk(T_HDR, 'h200));
        pend[0*V+1].push_back(mk(T_PAY, 'h201));
        pend[0*V+1].push_back(mk(T_LST, 'h202));
        n0 = 0; first3 = -1; last0 = -1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (last_sr[1*P+0]) begin n0++; if (n0 == 3) last0 = c; end
            if (last_sr[1*P+3] && first3 < 0) first3 = c;
        end
        chk("lock_last_read", 64'(last0), 64'(2));
        chk("lock_wait_grant", 64'(first3), 64'(3));
        run(10);

        // Reset mid-packet with flits buffered and VC0 locked
        do_reset();
        link_credit = 2'b00;
        for (int i = 0; i < 4; i++) pend[2*V+0].push_back(mk(T_SGL, 'h600 + i));
        run(10);
        pend[0*V+0].push_back(mk(T_HDR, 'h700));
        pend[0*V+0].push_back(mk(T_PAY, 'h701));
        pend[0*V+0].push_back(mk(T_PAY, 'h702));
        run(5);
        do_reset();
        chk("midrst_valid", 64'(link_valid), 64'(0));
        chk("midrst_flit", 64'(link_flit), 64'(0));
        for (int i = 0; i < 4; i++) pend[3*V+0].push_back(mk(T_SGL, 'h800 + i));
        n = 0;
        repeat (15) begin step(); if (link_valid[0]) n++; end
        chk("midrst_credits", 64'(n), 64'(4));
        link_credit = 2'b11;
        run(10);

        // Randomized traffic
        do_reset();
        repeat (3000) begin
            for (int i = 0; i < P*V; i++) begin
                if (pend[i].size() == 0 && $urandom_range(99) < 25) begin
                    seq++;
                    if ($urandom_range(3) == 0) begin
                        pend[i].push_back(mk(T_SGL, seq << 8));
                    end else begin
                        pend[i].push_back(mk(T_HDR, seq << 8));
                        n = $urandom_range(3);
                        for (int k = 0; k < n; k++) pend[i].push_back(mk(T_PAY, (seq << 8) + k + 1));
                        pend[i].push_back(mk(T_LST, (seq << 8) + 255));
                    end
                end
            end
            link_credit = V'($urandom);
            step();
        end

        link_credit = '1;
        bound = 0;
        n = 1;
        while (n != 0 && bound < 1000) begin
            step();
            bound++;
            n = sb.size();
            for (int v = 0; v < V; v++) n += mq[v].size();
            for (int i = 0; i < P*V; i++) n += pend[i].size();
        end
        chk("drain_done", 64'(n), 64'(0));
        run(5);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
